// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, mul/div and load refill
// share the remaining slots round-robin, with a starvation counter that forces a pipeline stall.
module wb_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pipe_valid_i,
  input  logic [4:0]  pipe_waddr_i,
  input  logic [31:0] pipe_wdata_i,
  input  logic        md_valid_i,
  input  logic [4:0]  md_waddr_i,
  input  logic [31:0] md_wdata_i,
  output logic        md_ready_o,
  input  logic        ld_valid_i,
  input  logic [4:0]  ld_waddr_i,
  input  logic [31:0] ld_wdata_i,
  output logic        ld_ready_o,
  output logic        pipe_stall_o,
  output logic [1:0]  wb_sel_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
);

  typedef enum logic {MdLast, LdLast} sec_e;

  localparam logic [CNT_W-1:0] Limit = CNT_W'(STARVE_LIMIT);

  sec_e             last_q, last_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic [1:0]       wb_sel_q;
  logic             rf_we_q;
  logic [4:0]       rf_waddr_q;
  logic [31:0]      rf_wdata_q;

  logic        sec_pending, force_stall;
  logic        grant_pipe, grant_md, grant_ld, grant_any;
  logic [4:0]  win_addr;
  logic [31:0] win_data;
  logic [1:0]  win_sel;

  always_comb begin
    sec_pending = md_valid_i | ld_valid_i;
    force_stall = sec_pending & (wait_q == Limit);
    grant_pipe  = pipe_valid_i & ~force_stall;
    // On a tie the secondary that did not win last time goes first
    grant_md    = ~grant_pipe & md_valid_i & (~ld_valid_i | (last_q == LdLast));
    grant_ld    = ~grant_pipe & ld_valid_i & ~grant_md;
    grant_any   = grant_pipe | grant_md | grant_ld;

    win_addr = pipe_waddr_i;
    win_data = pipe_wdata_i;
    win_sel  = 2'b00;
    if (grant_md) begin
      win_addr = md_waddr_i;
      win_data = md_wdata_i;
      win_sel  = 2'b01;
    end else if (grant_ld) begin
      win_addr = ld_waddr_i;
      win_data = ld_wdata_i;
      win_sel  = 2'b10;
    end

    last_d = last_q;
    if (grant_md) begin
      last_d = MdLast;
    end else if (grant_ld) begin
      last_d = LdLast;
    end

    if (grant_md | grant_ld) begin
      wait_d = '0;
    end else if (sec_pending) begin
      wait_d = (wait_q == Limit) ? wait_q : wait_q + CNT_W'(1);
    end else begin
      wait_d = '0;
    end
  end

  assign md_ready_o   = grant_md & ~rst_i;
  assign ld_ready_o   = grant_ld & ~rst_i;
  assign pipe_stall_o = pipe_valid_i & force_stall & ~rst_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q     <= LdLast;
      wait_q     <= '0;
      wb_sel_q   <= 2'b00;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      last_q <= last_d;
      wait_q <= wait_d;
      if (grant_any) begin
        // Writes to x0 are consumed but never reach the register file
        rf_we_q    <= |win_addr;
        rf_waddr_q <= win_addr;
        rf_wdata_q <= win_data;
        wb_sel_q   <= win_sel;
      end else begin
        rf_we_q <= 1'b0;
      end
    end
  end

  assign wb_sel_o   = wb_sel_q;
  assign rf_we_o    = rf_we_q;
  assign rf_waddr_o = rf_waddr_q;
  assign rf_wdata_o = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Bench for wb_port_arbiter: directed scenarios then random traffic against a cycle-level
// reference model of the grant/starvation rules.
module tb_wb_port_arbiter;

  localparam int unsigned Lim = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_valid, md_valid, ld_valid;
  logic [4:0]  pipe_waddr, md_waddr, ld_waddr;
  logic [31:0] pipe_wdata, md_wdata, ld_wdata;
  logic        md_ready, ld_ready, pipe_stall, rf_we;
  logic [1:0]  wb_sel;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  int checks = 0;
  int errors = 0;

  // Reference model: winner codes 0 pipe, 1 md, 2 ld, 3 none
  int          m_starve, m_last, m_win, sec_wait;
  logic        m_stall = 1'b0;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_sel;
  logic        obs_stall, obs_mdr;

  always #5 clk = ~clk;

  wb_port_arbiter #(.STARVE_LIMIT(Lim), .CNT_W(3)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .pipe_valid_i(pipe_valid),
    .pipe_waddr_i(pipe_waddr),
    .pipe_wdata_i(pipe_wdata),
    .md_valid_i  (md_valid),
    .md_waddr_i  (md_waddr),
    .md_wdata_i  (md_wdata),
    .md_ready_o  (md_ready),
    .ld_valid_i  (ld_valid),
    .ld_waddr_i  (ld_waddr),
    .ld_wdata_i  (ld_wdata),
    .ld_ready_o  (ld_ready),
    .pipe_stall_o(pipe_stall),
    .wb_sel_o    (wb_sel),
    .rf_we_o     (rf_we),
    .rf_waddr_o  (rf_waddr),
    .rf_wdata_o  (rf_wdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_starve = 0;
    m_last   = 2;
    sec_wait = 0;
    m_stall  = 1'b0;
    m_we     = 1'b0;
    m_addr   = '0;
    m_data   = '0;
    m_sel    = 2'b00;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    logic sp;
    #1;
    sp = md_valid || ld_valid;
    if (pipe_valid && !(sp && m_starve >= Lim)) m_win = 0;
    else if (md_valid && ld_valid)              m_win = (m_last == 1) ? 2 : 1;
    else if (md_valid)                          m_win = 1;
    else if (ld_valid)                          m_win = 2;
    else                                        m_win = 3;
    m_stall   = pipe_valid && (m_win != 0);
    obs_stall = pipe_stall;
    obs_mdr   = md_ready;
    chk("pipe_stall", pipe_stall, m_stall);
    chk("md_ready", md_ready, m_win == 1);
    chk("ld_ready", ld_ready, m_win == 2);
    if (sp && !md_ready && !ld_ready) sec_wait++;
    else sec_wait = 0;
    chk("starve_bound", sec_wait <= Lim, 1);
    case (m_win)
      0: begin m_we = pipe_waddr != 0; m_addr = pipe_waddr; m_data = pipe_wdata; m_sel = 0; end
      1: begin m_we = md_waddr != 0;   m_addr = md_waddr;   m_data = md_wdata;   m_sel = 1; end
      2: begin m_we = ld_waddr != 0;   m_addr = ld_waddr;   m_data = ld_wdata;   m_sel = 2; end
      default: m_we = 1'b0;
    endcase
    if (m_win == 1 || m_win == 2) begin
      m_starve = 0;
      m_last   = m_win;
    end else if (sp) begin
      m_starve = (m_starve < Lim) ? m_starve + 1 : Lim;
    end else begin
      m_starve = 0;
    end
    @(posedge clk);
    #1;
    chk("rf_we", rf_we, m_we);
    chk("rf_waddr", rf_waddr, m_addr);
    chk("rf_wdata", rf_wdata, m_data);
    chk("wb_sel", wb_sel, m_sel);
    chk("wb_sel_legal", wb_sel != 2'b11, 1);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    pipe_valid = 0; pipe_waddr = 0; pipe_wdata = 0;
    md_valid = 1; md_waddr = 6; md_wdata = 32'h66;
    ld_valid = 0; ld_waddr = 0; ld_wdata = 0;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_wb_sel", wb_sel, 0);
    chk("rst_md_ready", md_ready, 0);
    repeat (2) @(negedge clk);
    md_valid = 0;
    rst = 1'b0;
    model_reset();

    // Plain pipeline write
    pipe_valid = 1; pipe_waddr = 5; pipe_wdata = 32'hDEADBEEF;
    step();
    chk("t1_we", rf_we, 1);
    chk("t1_addr", rf_waddr, 5);
    chk("t1_data", rf_wdata, 32'hDEADBEEF);
    chk("t1_sel", wb_sel, 0);

    // Secondaries alternate, md first after reset
    pipe_valid = 0;
    md_valid = 1; md_waddr = 3; md_wdata = 32'h3333;
    ld_valid = 1; ld_waddr = 4; ld_wdata = 32'h4444;
    step();
    chk("t2_addr0", rf_waddr, 3);
    chk("t2_sel0", wb_sel, 1);
    md_valid = 0;
    step();
    chk("t2_addr1", rf_waddr, 4);
    chk("t2_sel1", wb_sel, 2);
    ld_valid = 0;

    // Starvation forces a stall on the fifth cycle
    pipe_valid = 1; pipe_waddr = 7; pipe_wdata = 32'h77;
    md_valid = 1; md_waddr = 9; md_wdata = 32'h99;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("t3_stall", obs_stall, i == 4);
      chk("t3_addr", rf_waddr, (i == 4) ? 9 : 7);
    end
    md_valid = 0;

    // Writes to register 0 are accepted but suppressed
    pipe_waddr = 0; pipe_wdata = 32'h1234;
    step();
    chk("t4_pipe_x0_we", rf_we, 0);
    pipe_valid = 0;
    md_valid = 1; md_waddr = 0;
    step();
    chk("t4_md_x0_ready", obs_mdr, 1);
    chk("t4_md_x0_we", rf_we, 0);

    // Reset mid-starvation restarts the count
    pipe_valid = 1; pipe_waddr = 7; md_valid = 1; md_waddr = 9;
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("t5_rf_we", rf_we, 0);
    chk("t5_rf_waddr", rf_waddr, 0);
    chk("t5_rf_wdata", rf_wdata, 0);
    chk("t5_wb_sel", wb_sel, 0);
    chk("t5_md_ready", md_ready, 0);
    chk("t5_stall", pipe_stall, 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_restall", obs_stall, i == 4);
    end

    // Random traffic with protocol-respecting holds
    for (int i = 0; i < 10000; i++) begin
      int dens;
      dens = (i / 1250) % 4;
      if (!m_stall) begin
        pipe_valid = $urandom_range(3) <= dens;
        pipe_waddr = 5'($urandom);
        pipe_wdata = $urandom;
      end
      if (!md_valid) begin
        md_valid = $urandom_range(3) < ((dens % 2) + 1);
        md_waddr = 5'($urandom);
        md_wdata = $urandom;
      end
      if (!ld_valid) begin
        ld_valid = $urandom_range(3) < (((dens + 1) % 3) + 1);
        ld_waddr = 5'($urandom);
        ld_wdata = $urandom;
      end
      step();
      if (m_win == 1) md_valid = 0;
      if (m_win == 2) ld_valid = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
